// File: rtl/mask_scan_ctrl.sv
// mask_scan_ctrl: steps a mask-generator offset from first to last by step.
// Each new offset waits MASK_LAT cycles to settle before it is offered
// downstream with a valid/ready handshake. Accepted beats are counted.
module mask_scan_ctrl #(
   parameter int SEQ_WIDTH    = 20,
   parameter int OFFSET_WIDTH = 7,
   parameter int MASK_LAT     = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic [OFFSET_WIDTH-1:0] i_first,
   input  logic [OFFSET_WIDTH-1:0] i_last,
   input  logic [OFFSET_WIDTH-1:0] i_step,
   output logic [OFFSET_WIDTH-1:0] o_offset,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [OFFSET_WIDTH:0]   o_count
);

   // Reject parameter values the settle counter cannot represent.
   if (MASK_LAT < 1 || MASK_LAT > 15 || SEQ_WIDTH < 1) begin : g_bad_param
      $error("mask_scan_ctrl: MASK_LAT must be 1..15 and SEQ_WIDTH positive");
   end

   localparam logic [3:0] LAT = 4'(MASK_LAT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      VALID  = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t                  r_state, w_state_n;
   logic [OFFSET_WIDTH-1:0] r_offset, w_offset_n;
   logic [OFFSET_WIDTH-1:0] r_last, w_last_n;
   logic [OFFSET_WIDTH-1:0] r_step, w_step_n;
   logic [OFFSET_WIDTH:0]   r_count, w_count_n;
   logic [3:0]              r_settle, w_settle_n;
   logic                    r_valid, r_busy, r_done;
   logic [OFFSET_WIDTH:0]   w_sum;

   // One extra bit so an overflowing sum compares above any legal last offset.
   assign w_sum = {1'b0, r_offset} + {1'b0, r_step};

   // State and all output registers; reset clears everything asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_offset <= '0;
         r_last   <= '0;
         r_step   <= '0;
         r_count  <= '0;
         r_settle <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_n;
         r_offset <= w_offset_n;
         r_last   <= w_last_n;
         r_step   <= w_step_n;
         r_count  <= w_count_n;
         r_settle <= w_settle_n;
         r_valid  <= (w_state_n == VALID);
         r_busy   <= (w_state_n != IDLE);
         r_done   <= (w_state_n == DONE);
      end
   end

   // Next-state and next-register values; abort wins over any handshake.
   always_comb begin
      w_state_n  = r_state;
      w_offset_n = r_offset;
      w_last_n   = r_last;
      w_step_n   = r_step;
      w_count_n  = r_count;
      w_settle_n = r_settle;
      case (r_state)
         IDLE: begin
            if (i_start && !i_abort) begin
               w_last_n  = i_last;
               w_step_n  = (i_step == '0) ? OFFSET_WIDTH'(1) : i_step;
               w_count_n = '0;
               if (i_first > i_last) begin
                  w_state_n = DONE;
               end else begin
                  w_offset_n = i_first;
                  w_settle_n = LAT;
                  w_state_n  = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (i_abort) begin
               w_state_n = IDLE;
            end else if (r_settle <= 4'd1) begin
               w_state_n = VALID;
            end else begin
               w_settle_n = r_settle - 4'd1;
            end
         end
         VALID: begin
            if (i_abort) begin
               w_state_n = IDLE;
            end else if (i_ready) begin
               w_count_n = r_count + 1'b1;
               if (w_sum > {1'b0, r_last}) begin
                  w_state_n = DONE;
               end else begin
                  w_offset_n = w_sum[OFFSET_WIDTH-1:0];
                  w_settle_n = LAT;
                  w_state_n  = SETTLE;
               end
            end
         end
         DONE: begin
            w_state_n = IDLE;
         end
         default: begin
            w_state_n = IDLE;
         end
      endcase
   end

   assign o_offset = r_offset;
   assign o_valid  = r_valid;
   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_count  = r_count;

endmodule

// File: tb/tb_mask_scan_ctrl.sv
// Bench for mask_scan_ctrl: directed scans; expected beats and final counts
// are queued by the driver and consumed by an independent monitor.
module tb_mask_scan_ctrl;

   localparam int OW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_start = 1'b0;
   logic          i_abort = 1'b0;
   logic [OW-1:0] i_first = '0;
   logic [OW-1:0] i_last = '0;
   logic [OW-1:0] i_step = '0;
   logic          i_ready = 1'b0;
   logic [OW-1:0] o_offset;
   logic          o_valid;
   logic          o_busy;
   logic          o_done;
   logic [OW:0]   o_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int prev_cyc = 0;
   bit have_prev = 0;
   bit chk_spacing = 0;
   int exp_beats[$];
   int exp_done[$];

   mask_scan_ctrl #(.SEQ_WIDTH(20), .OFFSET_WIDTH(OW), .MASK_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_first(i_first), .i_last(i_last), .i_step(i_step),
      .o_offset(o_offset), .o_valid(o_valid), .i_ready(i_ready),
      .o_busy(o_busy), .o_done(o_done), .o_count(o_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: a beat is whatever the DUT will hand over on the coming edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_valid && i_ready && !i_abort) begin
            if (exp_beats.size() == 0) chk("beat_unexpected", int'(o_offset), -1);
            else chk("beat_offset", int'(o_offset), exp_beats.pop_front());
            if (chk_spacing) begin
               if (have_prev) chk("beat_spacing", cyc - prev_cyc, 2);
               prev_cyc = cyc;
               have_prev = 1;
            end
         end
         if (o_done) begin
            if (exp_done.size() == 0) chk("done_unexpected", int'(o_count), -1);
            else chk("done_count", int'(o_count), exp_done.pop_front());
         end
      end
   end

   // Caller is always positioned 1 time unit after a rising edge.
   task automatic start_scan(input int f, input int l, input int s);
      i_first = OW'(f); i_last = OW'(l); i_step = OW'(s); i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!o_busy) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk({name, "_finished"}, int'(ok), 1);
      chk({name, "_beats_left"}, exp_beats.size(), 0);
      chk({name, "_done_left"}, exp_done.size(), 0);
      exp_beats.delete();
      exp_done.delete();
   endtask

   task automatic wait_beat(input int off, input string name);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (o_valid && int'(o_offset) == off) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      chk({name, "_reached"}, int'(ok), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_offset", int'(o_offset), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_count", int'(o_count), 0);
      rst_n = 1'b1;
      i_ready = 1'b1;
      @(posedge clk); #1;

      // Full range, step 1, ready tied high: 128 beats two cycles apart
      for (int k = 0; k < 128; k++) exp_beats.push_back(k);
      exp_done.push_back(128);
      chk_spacing = 1; have_prev = 0;
      start_scan(0, 127, 1);
      wait_idle("full");
      chk_spacing = 0;
      chk("full_count", int'(o_count), 128);

      // Step 7 from 10 to 30, started right after the previous scan
      exp_beats.push_back(10); exp_beats.push_back(17); exp_beats.push_back(24);
      exp_done.push_back(3);
      start_scan(10, 30, 7);
      wait_idle("step7");

      // Overflowing sum ends the scan after one beat
      exp_beats.push_back(120);
      exp_done.push_back(1);
      start_scan(120, 127, 100);
      wait_idle("ovf");
      chk("ovf_offset_kept", int'(o_offset), 120);

      // Backpressure on the second beat: 17 held for 5 cycles
      exp_beats.push_back(10); exp_beats.push_back(17); exp_beats.push_back(24);
      exp_done.push_back(3);
      start_scan(10, 30, 7);
      wait_beat(10, "bp");
      @(posedge clk); #1;
      i_ready = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid_held", int'(o_valid), 1);
         chk("bp_offset_held", int'(o_offset), 17);
         @(posedge clk); #1;
      end
      i_ready = 1'b1;
      wait_idle("bp");
      chk("bp_count", int'(o_count), 3);

      // first > last: straight to DONE; a start held into DONE is ignored
      exp_done.push_back(0);
      i_first = 7'd50; i_last = 7'd40; i_step = 7'd1; i_start = 1'b1;
      @(posedge clk); #1;
      chk("empty_done", int'(o_done), 1);
      chk("empty_valid", int'(o_valid), 0);
      @(posedge clk); #1;
      i_start = 1'b0;
      chk("empty_start_in_done_ignored", int'(o_busy), 0);
      chk("empty_done_pulse", int'(o_done), 0);
      wait_idle("empty");
      chk("empty_count", int'(o_count), 0);

      // Abort while a beat is being handed over: not counted, no done
      exp_beats.push_back(10);
      start_scan(10, 30, 7);
      wait_beat(17, "abort");
      i_abort = 1'b1;
      @(posedge clk); #1;
      i_abort = 1'b0;
      chk("abort_valid", int'(o_valid), 0);
      chk("abort_busy", int'(o_busy), 0);
      chk("abort_done", int'(o_done), 0);
      chk("abort_count", int'(o_count), 1);
      wait_idle("abort");

      // Start together with abort in IDLE is ignored
      i_first = 7'd1; i_last = 7'd2; i_step = 7'd1; i_start = 1'b1; i_abort = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0; i_abort = 1'b0;
      chk("start_abort_busy", int'(o_busy), 0);

      // Asynchronous reset in SETTLE, then stay idle
      start_scan(20, 60, 3);
      chk("settle_busy", int'(o_busy), 1);
      chk("settle_offset", int'(o_offset), 20);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_offset", int'(o_offset), 0);
      chk("arst_valid", int'(o_valid), 0);
      chk("arst_busy", int'(o_busy), 0);
      chk("arst_done", int'(o_done), 0);
      chk("arst_count", int'(o_count), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("post_rst_idle", int'(o_busy | o_valid), 0);
      end

      // Step 0 behaves as step 1
      exp_beats.push_back(5); exp_beats.push_back(6); exp_beats.push_back(7);
      exp_done.push_back(3);
      start_scan(5, 7, 0);
      wait_idle("step0");

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
